// File: rtl/updown_counter_n.sv
// Bounded up/down counter with load and clear, saturating or wrapping at
// 0 and MAX_VAL, with registered one-cycle overflow/underflow pulses.
module updown_counter_n #(
  parameter int WIDTH   = 5,
  parameter int MAX_VAL = (1 << WIDTH) - 1,
  parameter bit WRAP    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             cntU,
  input  logic             cntD,
  output logic [WIDTH-1:0] result,
  output logic             down_done,
  output logic             up_done,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  always_comb begin
    result_d = result_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    if (clr) begin
      result_d = '0;
    end else if (ld) begin
      // Out-of-range loads clamp so result can never exceed MAX_VAL.
      result_d = (ld_val > MAX_Q) ? MAX_Q : ld_val;
    end else if (cntU && cntD) begin
      result_d = result_q;
    end else if (cntU) begin
      if (result_q == MAX_Q) begin
        ovf_d = 1'b1;
        if (WRAP) result_d = '0;
      end else begin
        result_d = result_q + WIDTH'(1);
      end
    end else if (cntD) begin
      if (result_q == '0) begin
        udf_d = 1'b1;
        if (WRAP) result_d = MAX_Q;
      end else begin
        result_d = result_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign result    = result_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign down_done = (result_q == '0);
  assign up_done   = (result_q == MAX_Q);

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed bench: a saturating (WRAP=0) and a wrapping (WRAP=1) counter,
// both MAX_VAL=20, driven from shared inputs.
module tb_updown_counter_n;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       ld = 1'b0;
  logic [4:0] ld_val = '0;
  logic       cntU = 1'b0;
  logic       cntD = 1'b0;

  logic [4:0] r0, r1;
  logic       dn0, up0, ov0, un0;
  logic       dn1, up1, ov1, un1;

  int checks = 0;
  int errors = 0;

  updown_counter_n #(.WIDTH(5), .MAX_VAL(20), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val),
    .cntU(cntU), .cntD(cntD), .result(r0), .down_done(dn0),
    .up_done(up0), .ovf(ov0), .udf(un0)
  );

  updown_counter_n #(.WIDTH(5), .MAX_VAL(20), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val),
    .cntU(cntU), .cntD(cntD), .result(r1), .down_done(dn1),
    .up_done(up1), .ovf(ov1), .udf(un1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       clr;
    logic       ld;
    logic [4:0] ldv;
    logic       u;
    logic       d;
    logic [4:0] res;
    logic       up;
    logic       dn;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vt [18];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_sat(input string tag, input int res, input int up,
                           input int dn, input int ov, input int un);
    check({tag, ".result"}, int'(r0), res);
    check({tag, ".up_done"}, int'(up0), up);
    check({tag, ".down_done"}, int'(dn0), dn);
    check({tag, ".ovf"}, int'(ov0), ov);
    check({tag, ".udf"}, int'(un0), un);
  endtask

  task automatic check_wrap(input string tag, input int res, input int up,
                            input int dn, input int ov, input int un);
    check({tag, ".w.result"}, int'(r1), res);
    check({tag, ".w.up_done"}, int'(up1), up);
    check({tag, ".w.down_done"}, int'(dn1), dn);
    check({tag, ".w.ovf"}, int'(ov1), ov);
    check({tag, ".w.udf"}, int'(un1), un);
  endtask

  // Apply inputs, take one rising edge, sample 1ns later.
  task automatic step(input logic c, input logic l, input logic [4:0] lv,
                      input logic u, input logic d);
    clr = c; ld = l; ld_val = lv; cntU = u; cntD = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          clr  ld  ldv    u  d   res  up dn ov un
    vt[0]  = '{1'b0,1'b0,5'd0, 1'b0,1'b1,5'd19,1'b0,1'b0,1'b0,1'b0};
    vt[1]  = '{1'b0,1'b1,5'd7, 1'b1,1'b0,5'd7, 1'b0,1'b0,1'b0,1'b0};
    vt[2]  = '{1'b0,1'b1,5'd30,1'b0,1'b0,5'd20,1'b1,1'b0,1'b0,1'b0};
    vt[3]  = '{1'b1,1'b1,5'd5, 1'b1,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0};
    vt[4]  = '{1'b0,1'b0,5'd0, 1'b0,1'b1,5'd0, 1'b0,1'b1,1'b0,1'b1};
    vt[5]  = '{1'b0,1'b0,5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0};
    vt[6]  = '{1'b0,1'b0,5'd0, 1'b1,1'b0,5'd1, 1'b0,1'b0,1'b0,1'b0};
    vt[7]  = '{1'b0,1'b1,5'd12,1'b0,1'b0,5'd12,1'b0,1'b0,1'b0,1'b0};
    vt[8]  = '{1'b0,1'b0,5'd0, 1'b1,1'b1,5'd12,1'b0,1'b0,1'b0,1'b0};
    vt[9]  = '{1'b0,1'b0,5'd0, 1'b1,1'b1,5'd12,1'b0,1'b0,1'b0,1'b0};
    vt[10] = '{1'b0,1'b0,5'd0, 1'b1,1'b1,5'd12,1'b0,1'b0,1'b0,1'b0};
    vt[11] = '{1'b0,1'b1,5'd20,1'b0,1'b1,5'd20,1'b1,1'b0,1'b0,1'b0};
    vt[12] = '{1'b0,1'b0,5'd0, 1'b1,1'b0,5'd20,1'b1,1'b0,1'b1,1'b0};
    vt[13] = '{1'b0,1'b0,5'd0, 1'b0,1'b1,5'd19,1'b0,1'b0,1'b0,1'b0};
    vt[14] = '{1'b1,1'b0,5'd0, 1'b0,1'b1,5'd0, 1'b0,1'b1,1'b0,1'b0};
    vt[15] = '{1'b0,1'b0,5'd0, 1'b0,1'b1,5'd0, 1'b0,1'b1,1'b0,1'b1};
    vt[16] = '{1'b0,1'b0,5'd0, 1'b1,1'b0,5'd1, 1'b0,1'b0,1'b0,1'b0};
    vt[17] = '{1'b0,1'b1,5'd31,1'b0,1'b0,5'd20,1'b1,1'b0,1'b0,1'b0};

    // Asynchronous reset: outputs settle before any clock edge.
    #1 rst = 1'b1;
    #1;
    check_sat("reset", 0, 0, 1, 0, 0);
    check_wrap("reset", 0, 0, 1, 0, 0);
    @(posedge clk); #3 rst = 1'b0;
    #1;

    // Count up 25 edges: saturate at 20, ovf follows edges 21..25.
    for (int k = 1; k <= 25; k++) begin
      step(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      $display("up edge %0d: result=%0d up_done=%0d ovf=%0d", k, r0, up0, ov0);
      check_sat($sformatf("up%0d", k), (k > 20) ? 20 : k, (k >= 20) ? 1 : 0,
                0, (k > 20) ? 1 : 0, 0);
    end
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_sat("up_idle", 20, 1, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      step(vt[i].clr, vt[i].ld, vt[i].ldv, vt[i].u, vt[i].d);
      $display("vec %0d: result=%0d up=%0d dn=%0d ovf=%0d udf=%0d",
               i, r0, up0, dn0, ov0, un0);
      check_sat($sformatf("vec%0d", i), int'(vt[i].res), int'(vt[i].up),
                int'(vt[i].dn), int'(vt[i].ov), int'(vt[i].un));
    end

    // Wrap sequence, both instances freshly reset.
    #2 rst = 1'b1; #2 rst = 1'b0;
    step(1'b0, 1'b1, 5'd20, 1'b0, 1'b0);
    $display("wrap ld20: sat=%0d wrap=%0d", r0, r1);
    check_wrap("w_ld", 20, 1, 0, 0, 0);
    check_sat("w_ld", 20, 1, 0, 0, 0);
    step(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    $display("wrap up: sat=%0d wrap=%0d ovf=%0d", r0, r1, ov1);
    check_wrap("w_up", 0, 0, 1, 1, 0);
    check_sat("w_up", 20, 1, 0, 1, 0);
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    $display("wrap down: sat=%0d wrap=%0d udf=%0d", r0, r1, un1);
    check_wrap("w_dn", 20, 1, 0, 0, 1);
    check_sat("w_dn", 19, 0, 0, 0, 0);
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_wrap("w_idle", 20, 1, 0, 0, 0);

    // Reset mid-count while an ovf pulse is showing: no pulse after release.
    step(1'b0, 1'b1, 5'd20, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    check_sat("pre_rst", 20, 1, 0, 1, 0);
    cntU = 1'b0;
    #2 rst = 1'b1;
    #1;
    $display("mid-reset: result=%0d ovf=%0d", r0, ov0);
    check_sat("mid_rst", 0, 0, 1, 0, 0);
    check_wrap("mid_rst", 0, 0, 1, 0, 0);
    #2 rst = 1'b0;
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_sat("post_rst", 0, 0, 1, 0, 0);
    step(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    check_sat("post_rst_up", 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_n.md
UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the counter width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter MAX_VAL, default 2^WIDTH-1, giving the upper count limit (legal range 1..2^WIDTH-1).
REQ-003 The block SHALL have parameter WRAP, default 0: 0 = saturate at bounds, 1 = wrap modulo (MAX_VAL+1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clr  input  1  synchronous clear to 0, active-high.
REQ-007 ld  input  1  synchronous load of ld_val, active-high.
REQ-008 ld_val  input  WIDTH  load value.
REQ-009 cntU  input  1  count-up request.
REQ-010 cntD  input  1  count-down request.
REQ-011 result  output  WIDTH  current count, registered.
REQ-012 down_done  output  1  combinational flag: result == 0.
REQ-013 up_done  output  1  combinational flag: result == MAX_VAL.
REQ-014 ovf  output  1  registered one-cycle pulse: up request attempted at MAX_VAL.
REQ-015 udf  output  1  registered one-cycle pulse: down request attempted at 0.

Function
REQ-016 Per-edge priority SHALL be: clr > ld > (cntU and cntD) > cntU > cntD > hold.
REQ-017 clr SHALL set result to 0 on the next edge regardless of other inputs; ovf and udf SHALL be 0 that cycle.
REQ-018 ld SHALL set result to ld_val; ld_val > MAX_VAL SHALL load MAX_VAL (clamp); ovf/udf 0 that cycle.
REQ-019 cntU and cntD both high SHALL hold result, with ovf/udf 0.
REQ-020 cntU alone with result < MAX_VAL SHALL increment result by 1 on the next edge.
REQ-021 cntU alone with result == MAX_VAL SHALL hold (WRAP=0) or load 0 (WRAP=1), and SHALL assert ovf for exactly the following cycle.
REQ-022 cntD alone with result > 0 SHALL decrement result by 1 on the next edge.
REQ-023 cntD alone with result == 0 SHALL hold (WRAP=0) or load MAX_VAL (WRAP=1), and SHALL assert udf for exactly the following cycle.
REQ-024 Latency from request to updated result SHALL be one clock edge; flags SHALL track result with zero additional latency.
REQ-025 result SHALL never exceed MAX_VAL in any mode; arithmetic SHALL be WIDTH bits with no unsigned overflow visible at result.
REQ-026 ovf and udf SHALL never be high in the same cycle.
REQ-027 Back-to-back requests on consecutive edges SHALL each take effect (one step per edge, no dead cycles).

Reset
REQ-028 rst high SHALL immediately, without a clock edge, force result=0, ovf=0, udf=0; down_done=1, up_done=0.
REQ-029 rst asserted mid-count SHALL abort the operation; no ovf/udf pulse SHALL follow reset release.
REQ-030 After rst deassertion the first rising edge SHALL process inputs normally.

Verification
REQ-031 WIDTH=5, MAX_VAL=20, WRAP=0: reset, cntU for 25 edges -> result 1..20 then holds 20; up_done=1 from edge 20; ovf high one cycle after each of edges 21..25.
REQ-032 Same config: from 0, cntD one edge -> result stays 0, down_done=1, udf pulses one cycle; result never 31.
REQ-033 WRAP=1, MAX_VAL=20: result=20, cntU -> result 0, ovf=1 one cycle; then cntD -> result 20, udf=1 one cycle.
REQ-034 ld with ld_val=7 and cntU=1 same edge -> result 7; ld_val=30 -> result 20; clr with ld=1 -> result 0.
REQ-035 result=12, cntU=cntD=1 for 3 edges -> result 12, no pulses; rst asserted between edges -> result 0 before next edge, no pulse after release.
